snell_sine_stage: RTL and testbench
===================================

// Module: snell_sine_stage
// PURPOSE
//  Upstream feeder for the snell_law index calculator. Accepts (n2, theeta1, theeta2) samples
//  over a valid/ready handshake and looks up sin(theeta1) and sin(theeta2) in an integer-degree
//  sine ROM. Emits the sines with n2 and error flags through a 2-stage backpressured pipeline.
//  The consumer computes n1 = n2*sin2/sin1 and must not divide by a zero or out-of-range sine.
// PARAMETERS
//  SIN_W    13   sine output width, unsigned fixed point, 4096 = 1.0 (sin 90 deg)
//  ANG_MAX  90   largest legal angle in degrees; larger angles are flagged
//  ECNT_W   8    width of the saturating error counter
// PORTS
//  clk        in   1      system clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      sample present on in_*
//  in_ready   out  1      stage can accept this cycle
//  in_n2      in   4      refractive index of medium 2, integer code
//  in_th1     in   7      incidence angle theeta1, degrees 0..127
//  in_th2     in   7      refraction angle theeta2, degrees 0..127
//  out_valid  out  1      result present on out_*
//  out_ready  in   1      consumer takes result this cycle
//  out_n2     out  4      n2 passed through, aligned with the sines
//  out_sin1   out  SIN_W  round(4096*sin(th1)), or 0 if th1 > ANG_MAX
//  out_sin2   out  SIN_W  round(4096*sin(th2)), or 0 if th2 > ANG_MAX
//  out_err    out  2      [0] angle range error (th1 or th2 > ANG_MAX); [1] sin1 == 0 (th1 == 0)
//  err_cnt    out  ECNT_W count of results delivered with out_err != 0, saturates at all-ones
// BEHAVIOUR
//  - Reset (async assert): in_ready=0 while rst=1; out_valid=0, out_n2=0, out_sin1/2=0,
//    out_err=0, err_cnt=0. All in-flight samples are discarded. in_ready=1 on the first
//    cycle after rst is released.
//  - Handshake: a transfer occurs when valid & ready are both high at a rising edge. out_* stay
//    stable while out_valid=1 and out_ready=0. out_valid never drops without a transfer.
//    in_ready does not depend combinationally on in_valid.
//  - Pipeline: S1 registers the sample and computes the range/zero checks. S2 registers the ROM
//    outputs. Latency from input transfer to out_valid is 2 cycles. Throughput is 1 sample per
//    cycle while out_ready=1.
//  - Backpressure: a stage advances when the next stage is empty or is emptying this cycle.
//    in_ready = !s1_valid | s2_advance. With out_ready held at 0, exactly 2 samples are held and
//    in_ready drops after the 2nd.
//  - ROM: 91 entries, index 0..90, value = round(4096*sin(d*pi/180)). Examples: 0->0, 3->214,
//    30->2048, 45->2896, 60->3547, 90->4096. An index > ANG_MAX gives 0 and sets out_err[0].
//  - out_err[1] is set when th1 == 0 or th1 > ANG_MAX. Both bits can be set at once.
//  - err_cnt increments on each output transfer with out_err != 0, and holds at 2^ECNT_W-1.
//  - Simultaneous input and output transfers in the same cycle keep full throughput.
//    No sample is lost or duplicated.
// STRUCTURE
//  - snell_pkg: SIN_W, ANG_MAX, the sine-table constant, and the err bit indices
//    (ERR_RANGE=0, ERR_DIV0=1).
//  - Sub-module snell_sin_lut: combinational ROM, 7-bit angle in, SIN_W sine out, plus a range
//    flag. Two instances, one per angle.
//  - Top: two valid/data register stages, the advance logic, and the error counter.
// TESTING
//  1. Reset, then n2=10, th1=3, th2=3, one beat -> 2 cycles later out_sin1=out_sin2=214,
//     out_n2=10, out_err=0.
//  2. Stream th1/th2 = (30,45), (60,90), (90,0) back-to-back with out_ready=1 ->
//     outputs (2048,2896), (3547,4096), (4096,0) on 3 consecutive cycles, in order.
//  3. th1=0, th2=30 -> out_sin1=0, out_err=2'b10, err_cnt goes 0->1.
//     Then th1=100, th2=20 -> out_sin1=0, out_err=2'b11, err_cnt=2.
//  4. out_ready=0, offer 4 samples -> 2 accepted, in_ready=0, out_* stable.
//     Release out_ready -> all 4 delivered in order, none dropped.
//  5. Assert rst with 2 samples in flight -> out_valid=0 and err_cnt=0 immediately (async).
//     After release, no stale sample appears.
//  6. Force 255+ error samples with ECNT_W=8 -> err_cnt saturates at 255.

Source files
------------

// File: rtl/snell_pkg.sv
// Shared constants for the snell sine stage: widths, error bit positions and the
// integer-degree sine table (4096 = 1.0).
package snell_pkg;

    localparam int SIN_W     = 13;
    localparam int ANG_W     = 7;
    localparam int ANG_MAX   = 90;
    localparam int ERR_W     = 2;
    localparam int ERR_RANGE = 0;
    localparam int ERR_DIV0  = 1;

    typedef logic [SIN_W-1:0] sin_t;
    typedef logic [ANG_W-1:0] ang_t;
    typedef logic [ERR_W-1:0] err_t;

    // round(4096 * sin(d degrees)) for d = 0..ANG_MAX
    localparam sin_t SIN_TABLE [0:ANG_MAX] = '{
           0,   71,  143,  214,  286,  357,  428,  499,  570,  641,
         711,  782,  852,  921,  991, 1060, 1129, 1198, 1266, 1334,
        1401, 1468, 1534, 1600, 1666, 1731, 1796, 1860, 1923, 1986,
        2048, 2110, 2171, 2231, 2290, 2349, 2408, 2465, 2522, 2578,
        2633, 2687, 2741, 2793, 2845, 2896, 2946, 2996, 3044, 3091,
        3138, 3183, 3228, 3271, 3314, 3355, 3396, 3435, 3474, 3511,
        3547, 3582, 3617, 3650, 3681, 3712, 3742, 3770, 3798, 3824,
        3849, 3873, 3896, 3917, 3937, 3956, 3974, 3991, 4006, 4021,
        4034, 4046, 4056, 4065, 4074, 4080, 4086, 4090, 4094, 4095,
        4096
    };

    function automatic logic ang_bad(input ang_t ang);
        return int'(ang) > ANG_MAX;
    endfunction

endpackage

// File: rtl/snell_sin_lut.sv
// Combinational sine ROM: integer-degree angle in, fixed-point sine out.
// Angles beyond the table read as zero and raise range_err.
module snell_sin_lut
    import snell_pkg::*;
(
    input  ang_t ang,
    output sin_t sin_val,
    output logic range_err
);

    always_comb begin
        range_err = ang_bad(ang);
        sin_val   = '0;
        if (!range_err) begin
            sin_val = SIN_TABLE[ang];
        end
    end

endmodule

// File: rtl/snell_sine_stage.sv
// Two-stage backpressured pipeline feeding the snell_law calculator: registers the
// sample, looks up both sines, and flags inputs the downstream divide cannot accept.
module snell_sine_stage
    import snell_pkg::*;
#(
    parameter int ECNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_n2,
    input  logic [ANG_W-1:0]  in_th1,
    input  logic [ANG_W-1:0]  in_th2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_n2,
    output logic [SIN_W-1:0]  out_sin1,
    output logic [SIN_W-1:0]  out_sin2,
    output logic [ERR_W-1:0]  out_err,
    output logic [ECNT_W-1:0] err_cnt
);

    logic       rdy_en;
    logic       vld_p1;
    logic [3:0] n2_p1;
    ang_t       th1_p1;
    ang_t       th2_p1;
    logic       zero_p1;
    logic       take_p1;
    logic       adv_p2;
    sin_t       sin1_c;
    sin_t       sin2_c;
    logic       rng1_c;
    logic       rng2_c;
    err_t       err_c;

    function automatic logic [ECNT_W-1:0] sat_inc(input logic [ECNT_W-1:0] v);
        return (&v) ? v : v + ECNT_W'(1);
    endfunction

    // Held low through reset so no sample is taken until the first clean edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
        end
    end

    assign adv_p2   = !out_valid || out_ready;
    assign in_ready = rdy_en && (!vld_p1 || adv_p2);
    assign take_p1  = in_valid && in_ready;

    // Stage 1: capture the sample and the divide-by-zero check
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else if (in_ready) begin
            vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (take_p1) begin
            n2_p1   <= in_n2;
            th1_p1  <= in_th1;
            th2_p1  <= in_th2;
            zero_p1 <= (in_th1 == '0);
        end
    end

    snell_sin_lut u_lut1 (
        .ang       (th1_p1),
        .sin_val   (sin1_c),
        .range_err (rng1_c)
    );

    snell_sin_lut u_lut2 (
        .ang       (th2_p1),
        .sin_val   (sin2_c),
        .range_err (rng2_c)
    );

    // An out-of-range th1 also reads as a zero sine, so it poisons the divide too.
    always_comb begin
        err_c            = '0;
        err_c[ERR_RANGE] = rng1_c || rng2_c;
        err_c[ERR_DIV0]  = zero_p1 || rng1_c;
    end

    // Stage 2: register ROM outputs; these drive the consumer directly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_n2    <= '0;
            out_sin1  <= '0;
            out_sin2  <= '0;
            out_err   <= '0;
            err_cnt   <= '0;
        end else begin
            if (adv_p2) begin
                out_valid <= vld_p1;
            end
            if (adv_p2 && vld_p1) begin
                out_n2   <= n2_p1;
                out_sin1 <= sin1_c;
                out_sin2 <= sin2_c;
                out_err  <= err_c;
            end
            if (out_valid && out_ready && (out_err != '0)) begin
                err_cnt <= sat_inc(err_cnt);
            end
        end
    end

endmodule

// File: tb/tb_snell_sine_stage.sv
// Bench for snell_sine_stage: constant vector table, directed handshake/reset
// sequences, and a randomized stream checked against a trigonometric reference.
`timescale 1ns/1ps
module tb_snell_sine_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_n2;
    logic [6:0]  in_th1;
    logic [6:0]  in_th2;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_n2;
    logic [12:0] out_sin1;
    logic [12:0] out_sin2;
    logic [1:0]  out_err;
    logic [7:0]  err_cnt;

    always #5 clk = ~clk;

    snell_sine_stage #(.ECNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_n2     (in_n2),
        .in_th1    (in_th1),
        .in_th2    (in_th2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_n2    (out_n2),
        .out_sin1  (out_sin1),
        .out_sin2  (out_sin2),
        .out_err   (out_err),
        .err_cnt   (err_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct { int n2; int s1; int s2; int err; } exp_t;
    typedef struct { int n2; int th1; int th2; int s1; int s2; int err; } vec_t;

    exp_t q[$];
    exp_t mon_e;
    int   mcnt = 0;
    int   accepted = 0;
    int   delivered = 0;
    int   dropped = 0;
    bit   prev_stall = 0;
    int   p_n2, p_s1, p_s2, p_err;
    vec_t tv [10];
    int   base;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int ref_sin(input int d);
        real r;
        if (d > 90) return 0;
        r = 4096.0 * $sin(real'(d) * 3.14159265358979323846 / 180.0);
        return $rtoi(r + 0.5);
    endfunction

    function automatic exp_t ref_model(input int n2, input int t1, input int t2);
        exp_t e;
        e.n2  = n2;
        e.s1  = ref_sin(t1);
        e.s2  = ref_sin(t2);
        e.err = (((t1 == 0) || (t1 > 90)) ? 2 : 0) + (((t1 > 90) || (t2 > 90)) ? 1 : 0);
        return e;
    endfunction

    // Scoreboard: every accepted sample must come out once, in order, and hold under stall.
    always @(negedge clk) begin
        if (rst) begin
            dropped += q.size();
            q.delete();
            mcnt = 0;
            prev_stall = 0;
        end else begin
            chk("err_cnt", int'(err_cnt), mcnt);
            if (prev_stall) begin
                chk("hold_valid", int'(out_valid), 1);
                chk("hold_n2", int'(out_n2), p_n2);
                chk("hold_sin1", int'(out_sin1), p_s1);
                chk("hold_sin2", int'(out_sin2), p_s2);
                chk("hold_err", int'(out_err), p_err);
            end
            if (out_valid) begin
                chk("out_has_pending_in", int'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    mon_e = q[0];
                    chk("sb_n2", int'(out_n2), mon_e.n2);
                    chk("sb_sin1", int'(out_sin1), mon_e.s1);
                    chk("sb_sin2", int'(out_sin2), mon_e.s2);
                    chk("sb_err", int'(out_err), mon_e.err);
                    if (out_ready) begin
                        void'(q.pop_front());
                        delivered++;
                        if (mon_e.err != 0 && mcnt < 255) mcnt++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_model(int'(in_n2), int'(in_th1), int'(in_th2)));
                accepted++;
            end
            prev_stall = out_valid && !out_ready;
            p_n2  = int'(out_n2);
            p_s1  = int'(out_sin1);
            p_s2  = int'(out_sin2);
            p_err = int'(out_err);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int n2, input int t1, input int t2);
        bit ok;
        in_valid = 1'b1;
        in_n2    = 4'(n2);
        in_th1   = 7'(t1);
        in_th2   = 7'(t2);
        ok = 0;
        for (int k = 0; k < 100 && !ok; k++) begin
            #1;
            ok = in_ready;
            cyc();
        end
        chk("send_accepted", int'(ok), 1);
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && (q.size() != 0 || out_valid); k++) cyc();
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0] = '{10,   3,   3,  214,  214, 0};
        tv[1] = '{ 1,  30,  45, 2048, 2896, 0};
        tv[2] = '{ 2,  60,  90, 3547, 4096, 0};
        tv[3] = '{ 3,  90,   0, 4096,    0, 0};
        tv[4] = '{ 4,   0,  30,    0, 2048, 2};
        tv[5] = '{ 5, 100,  20,    0, 1401, 3};
        tv[6] = '{ 6,  91, 127,    0,    0, 3};
        tv[7] = '{ 7,  45,  91, 2896,    0, 1};
        tv[8] = '{ 8,   1,  89,   71, 4095, 0};
        tv[9] = '{ 9,  89,   1, 4095,   71, 0};

        rst = 1'b1; in_valid = 1'b0; in_n2 = '0; in_th1 = '0; in_th2 = '0; out_ready = 1'b1;
        repeat (3) cyc();
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_n2", int'(out_n2), 0);
        chk("rst_out_sin1", int'(out_sin1), 0);
        chk("rst_out_sin2", int'(out_sin2), 0);
        chk("rst_out_err", int'(out_err), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        rst = 1'b0;
        cyc();
        chk("ready_after_rst", int'(in_ready), 1);

        // error flags and counter steps
        chk("cnt_start", int'(err_cnt), 0);
        send(1, 0, 30); in_valid = 1'b0;
        cyc();
        chk("div0_err", int'(out_err), 2);
        chk("div0_sin1", int'(out_sin1), 0);
        chk("div0_sin2", int'(out_sin2), 2048);
        chk("div0_cnt_before", int'(err_cnt), 0);
        cyc();
        chk("div0_cnt_after", int'(err_cnt), 1);
        send(2, 100, 20); in_valid = 1'b0;
        cyc();
        chk("both_err", int'(out_err), 3);
        chk("both_sin1", int'(out_sin1), 0);
        chk("both_sin2", int'(out_sin2), 1401);
        cyc();
        chk("both_cnt", int'(err_cnt), 2);

        // vector table, one beat at a time with latency check
        for (int i = 0; i < 10; i++) begin
            send(tv[i].n2, tv[i].th1, tv[i].th2);
            in_valid = 1'b0;
            chk("tv_latency_early", int'(out_valid), 0);
            cyc();
            chk("tv_valid", int'(out_valid), 1);
            chk("tv_n2", int'(out_n2), tv[i].n2);
            chk("tv_sin1", int'(out_sin1), tv[i].s1);
            chk("tv_sin2", int'(out_sin2), tv[i].s2);
            chk("tv_err", int'(out_err), tv[i].err);
            cyc();
        end

        // back-to-back stream at full throughput
        send(1, 30, 45);
        chk("bb_lat", int'(out_valid), 0);
        send(2, 60, 90);
        chk("bb0_v", int'(out_valid), 1);
        chk("bb0_s1", int'(out_sin1), 2048);
        chk("bb0_s2", int'(out_sin2), 2896);
        send(3, 90, 0);
        chk("bb1_v", int'(out_valid), 1);
        chk("bb1_s1", int'(out_sin1), 3547);
        chk("bb1_s2", int'(out_sin2), 4096);
        in_valid = 1'b0;
        cyc();
        chk("bb2_v", int'(out_valid), 1);
        chk("bb2_s1", int'(out_sin1), 4096);
        chk("bb2_s2", int'(out_sin2), 0);
        chk("bb2_n2", int'(out_n2), 3);
        cyc();
        chk("bb_end", int'(out_valid), 0);

        // backpressure: two held, third refused, all four delivered later
        base = delivered;
        out_ready = 1'b0;
        send(11, 60, 45);
        send(12, 30, 3);
        in_valid = 1'b1; in_n2 = 4'd13; in_th1 = 7'd45; in_th2 = 7'd60;
        #1;
        chk("full_in_ready", int'(in_ready), 0);
        repeat (3) cyc();
        chk("stall_valid", int'(out_valid), 1);
        chk("stall_sin1", int'(out_sin1), 3547);
        chk("stall_n2", int'(out_n2), 11);
        out_ready = 1'b1;
        send(13, 45, 60);
        send(14, 90, 30);
        in_valid = 1'b0;
        drain();
        chk("bp_delivered", delivered - base, 4);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_n2     = 4'($urandom);
            in_th1    = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(91, 127)) : 7'($urandom_range(0, 90));
            in_th2    = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(91, 127)) : 7'($urandom_range(0, 90));
            out_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        // async reset with two samples in flight
        out_ready = 1'b0;
        send(5, 0, 10);
        send(6, 100, 10);
        in_valid = 1'b0;
        chk("pre_rst_valid", int'(out_valid), 1);
        rst = 1'b1;
        #1;
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_err_cnt", int'(err_cnt), 0);
        chk("arst_in_ready", int'(in_ready), 0);
        repeat (2) cyc();
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (6) begin
            cyc();
            chk("no_stale", int'(out_valid), 0);
        end

        // counter saturation
        for (int i = 0; i < 262; i++) send(i % 16, 0, 10);
        in_valid = 1'b0;
        drain();
        chk("cnt_saturated", int'(err_cnt), 255);
        send(1, 120, 5);
        in_valid = 1'b0;
        drain();
        chk("cnt_still_sat", int'(err_cnt), 255);

        chk("accounting", delivered + dropped, accepted);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
